// File: rtl/moonbase_io_bridge.sv
// moonbase_io_bridge: peripheral bridge on the moonbase CPU external bus.
// Latches a 7-bit device address from strobe cycles and assembles the CPU's
// two-nibble device writes into bytes. The bytes feed a GPIO output register,
// a one-shot prescaled timer with a sticky flag, an 8N1 UART transmitter and
// an ack register. A 2-bit read value is returned from the latched address.
module moonbase_io_bridge #(
  parameter int PRESCALE = 16,
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] bus_in,
  output logic [1:0] dev_out,
  input  logic [3:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       timer_irq,
  output logic       uart_tx
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);

  // Bus decode. A device write needs strobe low and device write_n low;
  // the RAM write_n and data_pc bits play no part here.
  logic       strobe, dev_wr, commit;
  logic [7:0] wr_byte;
  logic       wr_gpio, wr_tmr, wr_uart, wr_ack;

  logic [6:0] addr_q, addr_d;
  logic       hi_q, hi_d;
  logic [3:0] lo_buf_q, lo_buf_d;
  logic [7:0] gpio_q, gpio_d;

  logic [7:0]    tmr_cnt_q, tmr_cnt_d;
  logic          tmr_run_q, tmr_run_d;
  logic [PW-1:0] tmr_pre_q, tmr_pre_d;
  logic          irq_q, irq_d;
  logic          expire;

  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic [8:0]    shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_q, baud_d;

  assign strobe  = bus_in[7];
  assign dev_wr  = ~bus_in[7] & ~bus_in[4];
  assign commit  = dev_wr & hi_q;
  assign wr_byte = {bus_in[3:0], lo_buf_q};
  assign wr_gpio = commit && (addr_q == 7'h00);
  assign wr_tmr  = commit && (addr_q == 7'h01);
  assign wr_uart = commit && (addr_q == 7'h02);
  assign wr_ack  = commit && (addr_q == 7'h03);

  // Address latch, nibble pointer and GPIO register next-state.
  always_comb begin
    addr_d   = addr_q;
    hi_d     = hi_q;
    lo_buf_d = lo_buf_q;
    gpio_d   = gpio_q;
    if (strobe) begin
      addr_d = bus_in[6:0];
      hi_d   = 1'b0;
    end else if (dev_wr) begin
      if (!hi_q) begin
        lo_buf_d = bus_in[3:0];
        hi_d     = 1'b1;
      end else begin
        hi_d = 1'b0;
      end
    end
    if (wr_gpio) gpio_d = wr_byte;
  end

  // Timer next-state: prescaled countdown, reload wins over counting and
  // an expiry on the same edge as an ack leaves the flag set.
  always_comb begin
    tmr_cnt_d = tmr_cnt_q;
    tmr_run_d = tmr_run_q;
    tmr_pre_d = tmr_pre_q;
    expire    = 1'b0;
    if (tmr_run_q) begin
      if (tmr_pre_q == PRE_MAX) begin
        tmr_pre_d = '0;
        tmr_cnt_d = tmr_cnt_q - 8'd1;
        if (tmr_cnt_q == 8'd1) begin
          tmr_run_d = 1'b0;
          expire    = 1'b1;
        end
      end else begin
        tmr_pre_d = tmr_pre_q + 1'b1;
      end
    end
    if (wr_tmr) begin
      tmr_cnt_d = wr_byte;
      tmr_pre_d = '0;
      tmr_run_d = (wr_byte != 8'd0);
    end
    irq_d = (irq_q & ~(wr_ack & wr_byte[0])) | expire |
            (wr_tmr & (wr_byte == 8'd0));
  end

  // UART next-state: start bit goes out at the commit edge, then eight data
  // bits LSB-first and the stop bit, each held for BAUD_DIV cycles.
  always_comb begin
    busy_d    = busy_q;
    tx_d      = tx_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    if (busy_q) begin
      if (baud_q == BAUD_MAX) begin
        baud_d = '0;
        if (bit_cnt_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          tx_d      = shreg_q[0];
          shreg_d   = {1'b1, shreg_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end else if (wr_uart) begin
      busy_d    = 1'b1;
      tx_d      = 1'b0;
      shreg_d   = {1'b1, wr_byte};
      bit_cnt_d = 4'd0;
      baud_d    = '0;
    end
  end

  // State registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= 7'h7F;
      hi_q      <= 1'b0;
      lo_buf_q  <= 4'h0;
      gpio_q    <= 8'h00;
      tmr_cnt_q <= 8'h00;
      tmr_run_q <= 1'b0;
      tmr_pre_q <= '0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
      shreg_q   <= 9'h1FF;
      bit_cnt_q <= 4'd0;
      baud_q    <= '0;
    end else begin
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      lo_buf_q  <= lo_buf_d;
      gpio_q    <= gpio_d;
      tmr_cnt_q <= tmr_cnt_d;
      tmr_run_q <= tmr_run_d;
      tmr_pre_q <= tmr_pre_d;
      irq_q     <= irq_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
    end
  end

  // Device read mux from the latched address.
  always_comb begin
    case (addr_q)
      7'h00:   dev_out = gpio_in[1:0];
      7'h01:   dev_out = {tmr_run_q, irq_q};
      7'h02:   dev_out = {busy_q, 1'b0};
      7'h03:   dev_out = gpio_in[3:2];
      default: dev_out = 2'b00;
    endcase
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = irq_q;
  assign uart_tx   = tx_q;

endmodule
